// File: rtl/game_pkg.sv
// Shared types and constants for the round timer: FSM state enum,
// tog_start phase encodings, BCD digit type and a binary-to-BCD helper.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_RUN,
        S_P1_END,
        S_P2_RUN,
        S_P2_END
    } state_t;

    localparam logic [1:0] TOG_IDLE = 2'b00;
    localparam logic [1:0] TOG_P1   = 2'b01;
    localparam logic [1:0] TOG_P2   = 2'b11;

    typedef logic [3:0] bcd_t;

    // Two-digit BCD of a value in 0..99, tens in [7:4], ones in [3:0].
    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load. Decrements saturate
// at 00, so the displayed time can never wrap.
module bcd_down_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       load_i,
    input  logic [3:0] load_tens_i,
    input  logic [3:0] load_ones_i,
    input  logic       dec_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       zero_o
);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;

    assign tens_o = tens_q;
    assign ones_o = ones_q;
    assign zero_o = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Next digit value: load has priority, then a borrow-aware decrement.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load_i) begin
            tens_d = load_tens_i;
            ones_d = load_ones_i;
        end else if (dec_i && !zero_o) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    // Digit registers; reset is applied by the parent through load_i.
    always_ff @(posedge clk) begin
        tens_q <= tens_d;
        ones_q <= ones_d;
    end

endmodule

// File: rtl/game_round_timer.sv
// Round sequencer and per-player countdown timer. The FSM and the
// one-second prescaler live here; the BCD digits live in bcd_down_counter.
// Optional build macro GAME_TIMER_PAUSE_EN adds a 'pause' input that
// freezes the prescaler and digits while a round is running.
module game_round_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ROUND_SECS    = 30
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       finish1,
    input  logic       finish2,
`ifdef GAME_TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic [1:0] tog_start,
    output logic       enable1,
    output logic       enable2,
    output logic       time_out,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       sec_tick
);

    localparam int             PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]     INIT_BCD   = to_bcd(ROUND_SECS);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          time_out_q, time_out_d;
    logic          tick_q;
    logic [1:0]    tog_q, tog_d;
    logic          en1_q, en2_q;
    logic          load;
    logic          run, hold, tick, last_sec, zero;

`ifdef GAME_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign run      = (state_q == S_P1_RUN) || (state_q == S_P2_RUN);
    assign tick     = run && !hold && (presc_q == PRESC_MAX);
    // This tick takes the display from 01 to 00: the round expires now.
    assign last_sec = tick && (secs_tens == 4'd0) && (secs_ones == 4'd1);

    bcd_down_counter u_digits (
        .clk         (clk),
        .load_i      (rst || load),
        .load_tens_i (INIT_BCD[7:4]),
        .load_ones_i (INIT_BCD[3:0]),
        .dec_i       (tick),
        .tens_o      (secs_tens),
        .ones_o      (secs_ones),
        .zero_o      (zero)
    );

    // Next state, prescaler and time_out; finish beats expiry on a tie.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_out_d = time_out_q;
        load       = 1'b0;
        if (run && !hold)
            presc_d = tick ? '0 : presc_q + 1'b1;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_P1_RUN; load = 1'b1; presc_d = '0; time_out_d = 1'b0;
            end
            S_P1_RUN: begin
                if (finish1)       begin state_d = S_P1_END; time_out_d = 1'b0; end
                else if (last_sec) begin state_d = S_P1_END; time_out_d = 1'b1; end
            end
            S_P1_END: if (start) begin
                state_d = S_P2_RUN; load = 1'b1; presc_d = '0; time_out_d = 1'b0;
            end
            S_P2_RUN: begin
                if (finish2)       begin state_d = S_P2_END; time_out_d = 1'b0; end
                else if (last_sec) begin state_d = S_P2_END; time_out_d = 1'b1; end
            end
            S_P2_END: if (start) begin
                state_d = S_IDLE; load = 1'b1; presc_d = '0; time_out_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase code follows the state being entered so outputs change on the same edge.
    always_comb begin
        tog_d = TOG_IDLE;
        case (state_d)
            S_P1_RUN, S_P1_END: tog_d = TOG_P1;
            S_P2_RUN, S_P2_END: tog_d = TOG_P2;
            default:            tog_d = TOG_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            time_out_q <= 1'b0;
            tick_q     <= 1'b0;
            tog_q      <= TOG_IDLE;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            time_out_q <= time_out_d;
            tick_q     <= tick;
            tog_q      <= tog_d;
            en1_q      <= (state_d == S_P1_RUN);
            en2_q      <= (state_d == S_P2_RUN);
        end
    end

    assign tog_start = tog_q;
    assign enable1   = en1_q;
    assign enable2   = en2_q;
    assign time_out  = time_out_q;
    assign sec_tick  = tick_q;

endmodule

// File: tb/tb_game_round_timer.sv
// Directed bench for game_round_timer with TICKS_PER_SEC=4, ROUND_SECS=3.
module tb_game_round_timer;

    logic       clk = 1'b0;
    logic       rst, start, finish1, finish2;
    logic       pause;
    logic [1:0] tog_start;
    logic       enable1, enable2, time_out, sec_tick;
    logic [3:0] secs_tens, secs_ones;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_round_timer #(.TICKS_PER_SEC(4), .ROUND_SECS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish1   (finish1),
        .finish2   (finish2),
`ifdef GAME_TIMER_PAUSE_EN
        .pause     (pause),
`endif
        .tog_start (tog_start),
        .enable1   (enable1),
        .enable2   (enable2),
        .time_out  (time_out),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .sec_tick  (sec_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] tog, input logic e1,
                              input logic e2, input logic to, input logic [7:0] dig);
        check({tag, ".tog"}, 32'(tog_start), 32'(tog));
        check({tag, ".en1"}, 32'(enable1), 32'(e1));
        check({tag, ".en2"}, 32'(enable2), 32'(e2));
        check({tag, ".to"},  32'(time_out), 32'(to));
        check({tag, ".dig"}, 32'({secs_tens, secs_ones}), 32'(dig));
    endtask

    initial begin
        int ticks;
        rst = 1'b1; start = 1'b0; finish1 = 1'b0; finish2 = 1'b0; pause = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset then idle
        check_outs("reset", 2'b00, 0, 0, 0, 8'h03);
        check("reset.tick", 32'(sec_tick), 0);
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (sec_tick) ticks++;
        end
        check("idle.ticks", 32'(ticks), 0);
        check_outs("idle", 2'b00, 0, 0, 0, 8'h03);

        // Player 1 expiry, with an ignored start and finish2 at cycle 2
        pulse_start();
        check_outs("p1.entry", 2'b01, 1, 0, 0, 8'h03);
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) begin start = 1'b1; finish2 = 1'b1; end
            step();
            start = 1'b0; finish2 = 1'b0;
            check($sformatf("p1.tick%0d", c), 32'(sec_tick), 32'((c % 4) == 0));
            check($sformatf("p1.dig%0d", c), 32'({secs_tens, secs_ones}), 32'(3 - c / 4));
            if (c == 2)  check_outs("p1.ignored", 2'b01, 1, 0, 0, 8'h03);
            if (c == 11) check_outs("p1.pre_exp", 2'b01, 1, 0, 0, 8'h01);
        end
        check_outs("p1.expired", 2'b01, 0, 0, 1, 8'h00);
        for (int c = 0; c < 6; c++) step();
        check_outs("p1.end_hold", 2'b01, 0, 0, 1, 8'h00);
        check("p1.end_tick", 32'(sec_tick), 0);

        // Player 2 early finish, finish1 ignored at cycle 3
        pulse_start();
        check_outs("p2.entry", 2'b11, 0, 1, 0, 8'h03);
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) finish1 = 1'b1;
            if (c == 6) finish2 = 1'b1;
            step();
            finish1 = 1'b0; finish2 = 1'b0;
            if (c == 3) check_outs("p2.f1_ignored", 2'b11, 0, 1, 0, 8'h03);
        end
        check_outs("p2.finish", 2'b11, 0, 0, 0, 8'h02);
        for (int c = 0; c < 8; c++) step();
        check_outs("p2.frozen", 2'b11, 0, 0, 0, 8'h02);

        // Back to idle
        pulse_start();
        check_outs("p2.to_idle", 2'b00, 0, 0, 0, 8'h03);

        // Finish coincident with expiry
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (c == 12) finish1 = 1'b1;
            step();
            finish1 = 1'b0;
        end
        check_outs("tie", 2'b01, 0, 0, 0, 8'h00);
        check("tie.tick", 32'(sec_tick), 1);

        // Mid-round reset in P2_RUN at cycle 5
        pulse_start();
        check_outs("p2b.entry", 2'b11, 0, 1, 0, 8'h03);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) rst = 1'b1;
            step();
            rst = 1'b0;
            if (c == 4) check("p2b.dig4", 32'({secs_tens, secs_ones}), 32'h02);
        end
        check_outs("midrst", 2'b00, 0, 0, 0, 8'h03);
        step();
        check_outs("midrst.idle", 2'b00, 0, 0, 0, 8'h03);

`ifdef GAME_TIMER_PAUSE_EN
        // Pause for 10 cycles during P1_RUN delays expiry by exactly 10
        pulse_start();
        ticks = 0;
        for (int c = 1; c <= 22; c++) begin
            pause = (c >= 2 && c <= 11);
            step();
            pause = 1'b0;
            if (c >= 2 && c <= 11 && sec_tick) ticks++;
            if (c == 11) check("pause.dig", 32'({secs_tens, secs_ones}), 32'h03);
            if (c == 13) check("pause.notick13", 32'(sec_tick), 0);
            if (c == 14) check("pause.tick14", 32'(sec_tick), 1);
            if (c == 21) check_outs("pause.pre_exp", 2'b01, 1, 0, 0, 8'h01);
        end
        check("pause.ticks", 32'(ticks), 0);
        check_outs("pause.expired", 2'b01, 0, 0, 1, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
